// File: rtl/timer_pkg.sv
// Shared types and constants for the minutes/seconds countdown controller.
package timer_pkg;

    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] MAX_VAL = 6'd59;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0] min;
        logic [CNT_W-1:0] sec;
    } time_t;

    // Only ever applied to a non-zero time, so minutes cannot underflow.
    function automatic time_t dec_time(input time_t t);
        time_t r;
        if (t.sec != '0) begin
            r.min = t.min;
            r.sec = t.sec - 1'b1;
        end else begin
            r.min = t.min - 1'b1;
            r.sec = MAX_VAL;
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing one tick every TICK_DIV enabled cycles.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Holding the count while disabled is what preserves the partial second across a pause.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Countdown sequencing controller: command handling, load validation and mm:ss decrement.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | no countdown, counts 00:00
//   RUN     | counting down on each prescaler tick
//   PAUSE   | counts and prescaler frozen, start resumes
//   EXPIRED | reached 00:00, waits for a reload or clear
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic [CNT_W-1:0] load_min,
    input  logic [CNT_W-1:0] load_sec,
    output logic             busy,
    output logic             paused,
    output logic [CNT_W-1:0] count_minutes,
    output logic [CNT_W-1:0] count_seconds,
    output logic             done,
    output logic             expired,
    output logic             load_err
);

    state_t state;
    logic   tick;
    logic   load_ok;
    logic   load_zero;
    logic   load_go;
    logic   pre_clr;
    time_t  cur;
    time_t  nxt;

    assign load_ok   = (load_min <= MAX_VAL) && (load_sec <= MAX_VAL);
    assign load_zero = (load_min == '0) && (load_sec == '0);
    assign load_go   = !clear && start && load_ok && !load_zero
                       && ((state == IDLE) || (state == EXPIRED));
    assign pre_clr   = clear || load_go;

    assign cur = '{min: count_minutes, sec: count_seconds};
    assign nxt = dec_time(cur);

    assign busy    = (state == RUN);
    assign paused  = (state == PAUSE);
    assign expired = (state == EXPIRED);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (state == RUN),
        .clr   (pre_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            count_minutes <= '0;
            count_seconds <= '0;
            done          <= 1'b0;
            load_err      <= 1'b0;
        end else begin
            done     <= 1'b0;
            load_err <= 1'b0;
            if (clear) begin
                state         <= IDLE;
                count_minutes <= '0;
                count_seconds <= '0;
            end else begin
                case (state)
                    IDLE, EXPIRED: begin
                        if (start) begin
                            if (!load_ok) begin
                                load_err <= 1'b1;
                            end else if (load_zero) begin
                                state         <= EXPIRED;
                                count_minutes <= '0;
                                count_seconds <= '0;
                                done          <= 1'b1;
                            end else begin
                                state         <= RUN;
                                count_minutes <= load_min;
                                count_seconds <= load_sec;
                            end
                        end
                    end
                    RUN: begin
                        // A tick that lands on 00:00 takes precedence over a simultaneous pause.
                        if (tick) begin
                            count_minutes <= nxt.min;
                            count_seconds <= nxt.sec;
                            if ((nxt.min == '0) && (nxt.sec == '0)) begin
                                state <= EXPIRED;
                                done  <= 1'b1;
                            end else if (pause) begin
                                state <= PAUSE;
                            end
                        end else if (pause) begin
                            state <= PAUSE;
                        end
                    end
                    PAUSE: begin
                        if (start && !pause) begin
                            state <= RUN;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a 4-cycle tick.
module tb_timer_ctrl;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       clear = 1'b0;
    logic [5:0] load_min = '0;
    logic [5:0] load_sec = '0;
    logic       busy;
    logic       paused;
    logic [5:0] count_minutes;
    logic [5:0] count_seconds;
    logic       done;
    logic       expired;
    logic       load_err;

    int checks = 0;
    int failures = 0;

    timer_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .pause         (pause),
        .clear         (clear),
        .load_min      (load_min),
        .load_sec      (load_sec),
        .busy          (busy),
        .paused        (paused),
        .count_minutes (count_minutes),
        .count_seconds (count_seconds),
        .done          (done),
        .expired       (expired),
        .load_err      (load_err)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [5:0] m, input logic [5:0] s);
        load_min = m;
        load_sec = s;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        checks++;
        if ({busy, paused, done, expired, load_err, count_minutes, count_seconds} !== 17'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {busy, paused, done, expired, load_err, count_minutes, count_seconds});
        end
    endtask

    task automatic test_countdown();
        int done_cnt = 0;
        int done_at = -1;
        int zero_at = -1;
        do_load(6'd1, 6'd2);
        checks++;
        if (!(busy === 1'b1 && count_minutes === 6'd1 && count_seconds === 6'd2)) begin
            failures++;
            $display("FAIL cd_load: got busy=%b %0d:%0d required busy=1 1:2", busy, count_minutes, count_seconds);
        end
        step(4);
        checks++;
        if (!(count_minutes === 6'd1 && count_seconds === 6'd1)) begin
            failures++;
            $display("FAIL cd_tick1: got %0d:%0d required 1:1", count_minutes, count_seconds);
        end
        step(4);
        checks++;
        if (!(count_minutes === 6'd1 && count_seconds === 6'd0)) begin
            failures++;
            $display("FAIL cd_tick2: got %0d:%0d required 1:0", count_minutes, count_seconds);
        end
        step(4);
        checks++;
        if (!(count_minutes === 6'd0 && count_seconds === 6'd59)) begin
            failures++;
            $display("FAIL cd_borrow: got %0d:%0d required 0:59", count_minutes, count_seconds);
        end
        for (int c = 13; c <= 252; c++) begin
            step(1);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (zero_at < 0 && count_minutes === 6'd0 && count_seconds === 6'd0) zero_at = c;
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 248) begin
            failures++;
            $display("FAIL cd_done: got %0d pulses at cycle %0d required 1 at 248", done_cnt, done_at);
        end
        checks++;
        if (zero_at !== 248) begin
            failures++;
            $display("FAIL cd_zero_cycle: got %0d required 248", zero_at);
        end
        checks++;
        if (!(expired === 1'b1 && busy === 1'b0)) begin
            failures++;
            $display("FAIL cd_expired: got expired=%b busy=%b required 1 0", expired, busy);
        end
        do_clear();
        checks++;
        if (expired !== 1'b0) begin
            failures++;
            $display("FAIL cd_clear: got expired=%b required 0", expired);
        end
    endtask

    task automatic test_pause_resume();
        int frozen_bad = 0;
        do_load(6'd0, 6'd3);
        step(1);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        checks++;
        if (!(paused === 1'b1 && busy === 1'b0 && count_seconds === 6'd3)) begin
            failures++;
            $display("FAIL pr_enter: got paused=%b busy=%b sec=%0d required 1 0 3", paused, busy, count_seconds);
        end
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (count_seconds !== 6'd3 || paused !== 1'b1) frozen_bad++;
        end
        checks++;
        if (frozen_bad !== 0) begin
            failures++;
            $display("FAIL pr_frozen: got %0d bad cycles required 0", frozen_bad);
        end
        load_min = 6'd7;
        load_sec = 6'd7;
        start = 1'b1;
        step(1);
        start = 1'b0;
        checks++;
        if (!(busy === 1'b1 && count_minutes === 6'd0 && count_seconds === 6'd3)) begin
            failures++;
            $display("FAIL pr_resume: got busy=%b %0d:%0d required 1 0:3", busy, count_minutes, count_seconds);
        end
        step(1);
        checks++;
        if (count_seconds !== 6'd3) begin
            failures++;
            $display("FAIL pr_resume_hold: got sec=%0d required 3", count_seconds);
        end
        step(1);
        checks++;
        if (count_seconds !== 6'd2) begin
            failures++;
            $display("FAIL pr_first_tick: got sec=%0d required 2", count_seconds);
        end
        step(4);
        checks++;
        if (count_seconds !== 6'd1) begin
            failures++;
            $display("FAIL pr_second_tick: got sec=%0d required 1", count_seconds);
        end
        step(4);
        checks++;
        if (!(count_seconds === 6'd0 && done === 1'b1 && expired === 1'b1)) begin
            failures++;
            $display("FAIL pr_expire: got sec=%0d done=%b expired=%b required 0 1 1", count_seconds, done, expired);
        end
        do_clear();
    endtask

    task automatic test_pause_on_tick();
        do_load(6'd0, 6'd2);
        step(3);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        checks++;
        if (!(paused === 1'b1 && count_seconds === 6'd1)) begin
            failures++;
            $display("FAIL pt_pause_tick: got paused=%b sec=%0d required 1 1", paused, count_seconds);
        end
        do_clear();
        do_load(6'd0, 6'd1);
        step(3);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        checks++;
        if (!(paused === 1'b0 && expired === 1'b1 && done === 1'b1 && count_seconds === 6'd0)) begin
            failures++;
            $display("FAIL pt_expire_wins: got paused=%b expired=%b done=%b sec=%0d required 0 1 1 0",
                     paused, expired, done, count_seconds);
        end
        do_clear();
    endtask

    task automatic test_load_err();
        do_load(6'd60, 6'd0);
        checks++;
        if (!(load_err === 1'b1 && busy === 1'b0 && expired === 1'b0 && count_minutes === 6'd0 && count_seconds === 6'd0)) begin
            failures++;
            $display("FAIL le_min60: got err=%b busy=%b %0d:%0d required 1 0 0:0", load_err, busy, count_minutes, count_seconds);
        end
        step(1);
        checks++;
        if (load_err !== 1'b0) begin
            failures++;
            $display("FAIL le_pulse_width: got %b required 0", load_err);
        end
        do_load(6'd0, 6'd60);
        checks++;
        if (!(load_err === 1'b1 && busy === 1'b0)) begin
            failures++;
            $display("FAIL le_sec60: got err=%b busy=%b required 1 0", load_err, busy);
        end
        do_load(6'd59, 6'd59);
        checks++;
        if (!(load_err === 1'b0 && busy === 1'b1 && count_minutes === 6'd59 && count_seconds === 6'd59)) begin
            failures++;
            $display("FAIL le_max_ok: got err=%b busy=%b %0d:%0d required 0 1 59:59", load_err, busy, count_minutes, count_seconds);
        end
        do_clear();
    endtask

    task automatic test_zero_load();
        do_load(6'd0, 6'd0);
        checks++;
        if (!(done === 1'b1 && expired === 1'b1 && busy === 1'b0)) begin
            failures++;
            $display("FAIL zl_entry: got done=%b expired=%b busy=%b required 1 1 0", done, expired, busy);
        end
        step(1);
        checks++;
        if (!(done === 1'b0 && expired === 1'b1)) begin
            failures++;
            $display("FAIL zl_hold: got done=%b expired=%b required 0 1", done, expired);
        end
        do_load(6'd0, 6'd61);
        checks++;
        if (!(load_err === 1'b1 && expired === 1'b1)) begin
            failures++;
            $display("FAIL zl_bad_reload: got err=%b expired=%b required 1 1", load_err, expired);
        end
        do_load(6'd0, 6'd2);
        checks++;
        if (!(expired === 1'b0 && busy === 1'b1 && count_seconds === 6'd2)) begin
            failures++;
            $display("FAIL zl_rerun: got expired=%b busy=%b sec=%0d required 0 1 2", expired, busy, count_seconds);
        end
        do_clear();
    endtask

    task automatic test_clear_priority();
        do_load(6'd0, 6'd5);
        load_sec = 6'd9;
        clear = 1'b1;
        pause = 1'b1;
        start = 1'b1;
        step(1);
        clear = 1'b0;
        pause = 1'b0;
        start = 1'b0;
        checks++;
        if ({busy, paused, expired, count_minutes, count_seconds} !== 15'd0) begin
            failures++;
            $display("FAIL cp_all_cmds: got %b required all zero", {busy, paused, expired, count_minutes, count_seconds});
        end
    endtask

    task automatic test_reset_midrun();
        int stray = 0;
        do_load(6'd0, 6'd40);
        load_sec = 6'd10;
        start = 1'b1;
        step(1);
        start = 1'b0;
        checks++;
        if (!(busy === 1'b1 && count_seconds === 6'd40)) begin
            failures++;
            $display("FAIL rm_start_ignored: got busy=%b sec=%0d required 1 40", busy, count_seconds);
        end
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++;
        if ({busy, paused, done, expired, load_err, count_minutes, count_seconds} !== 17'd0) begin
            failures++;
            $display("FAIL rm_reset: got %b required all zero",
                     {busy, paused, done, expired, load_err, count_minutes, count_seconds});
        end
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        checks++;
        if (stray !== 0) begin
            failures++;
            $display("FAIL rm_quiet: got %0d active cycles required 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_pause_resume();
        test_pause_on_tick();
        test_load_err();
        test_zero_load();
        test_clear_priority();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Sequencing controller for the minutes/seconds countdown datapath.
- Accepts start/pause/clear commands and validates loaded time values.
- Generates the 1-second decrement enable from the system clock.
- Reports run state, current count, a one-cycle done pulse and a sticky expired flag. Sits between the user command logic and the display/alarm logic.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per countdown tick (1 s at 50 MHz); benches use 4.
- MAX_VAL, 59, largest legal minutes or seconds value.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  load-and-run (IDLE/EXPIRED) or resume (PAUSE).
- pause  input  1  freeze countdown (RUN only).
- clear  input  1  abort to IDLE from any state.
- load_min  input  6  minutes captured on a valid start.
- load_sec  input  6  seconds captured on a valid start.
- busy  output  1  high in RUN.
- paused  output  1  high in PAUSE.
- count_minutes  output  6  current minutes.
- count_seconds  output  6  current seconds.
- done  output  1  one-cycle pulse on entry to EXPIRED.
- expired  output  1  high while in EXPIRED.
- load_err  output  1  one-cycle pulse on a rejected start.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Reset overrides all inputs.
- Reset values: state=IDLE, counts=0, prescaler=0, and busy, paused, done, expired, load_err all 0.
- Outputs: all outputs are registered. busy, paused and expired decode the state register.
- Command priority in one cycle: reset > clear > pause > start.
- clear: in any state, goes to IDLE next cycle with counts=0, prescaler=0 and expired=0.
- IDLE + start:
  - If load_min>MAX_VAL or load_sec>MAX_VAL: load_err=1 for one cycle; state and counts unchanged.
  - Else if the load is 00:00: go to EXPIRED next cycle, done=1 that cycle, counts=0.
  - Else: latch the counts, clear the prescaler, go to RUN. Counts are visible the next cycle.
- RUN:
  - The prescaler increments 0..TICK_DIV-1 and wraps; a tick occurs on the cycle the prescaler equals TICK_DIV-1.
  - On a tick, if sec>0 then sec-1; else min-1 and sec=MAX_VAL.
  - If the post-decrement value is 00:00: go to EXPIRED, and done=1 in the same cycle the counts read 00:00.
  - The first decrement is visible TICK_DIV cycles after the load becomes visible.
  - start in RUN is ignored; there is no restart from RUN.
- pause in RUN: go to PAUSE. The prescaler holds its value (not cleared), so the partial second is preserved.
  - If pause coincides with a tick: the decrement is applied, then PAUSE is entered.
  - If that tick reaches 00:00: EXPIRED wins and pause is ignored.
- PAUSE:
  - start resumes RUN; load_min/load_sec are ignored.
  - The prescaler continues from its held value. Counts are frozen.
- EXPIRED:
  - expired=1, counts=00:00.
  - start with a valid non-zero load reloads and enters RUN, as from IDLE.
  - An invalid load gives load_err and stays in EXPIRED.
- pause in IDLE or EXPIRED: no effect.
- Arithmetic:
  - The prescaler is $clog2(TICK_DIV) bits wide, with a minimum of 1.
  - Counts never go below 0 and never exceed MAX_VAL.
  - No other wrap-around is possible by construction.
- Reset mid-RUN or mid-PAUSE: all reset values on the next edge; done does not fire.

Decomposition:
- Package timer_pkg:
  - state enum {IDLE, RUN, PAUSE, EXPIRED};
  - MAX_VAL=59;
  - count width constant CNT_W=6.
- Sub-module tick_prescaler:
  - ports clk, reset, en, clr, tick;
  - parameter TICK_DIV;
  - the FSM drives en=(state==RUN) and clr on load or clear.
- The FSM, count registers and validation stay in timer_ctrl.

Test Plan (TICK_DIV=4):
- Load 01:02 + start → busy=1, count 01:02 next cycle. Decrements to 01:01, then 01:00, then 00:59 at 4-cycle spacing. Exactly one done pulse when 00:00 appears 248 cycles after load visibility; expired=1 afterward.
- Load 00:03, run, pause when the prescaler reads 2, hold pause off for 10 cycles, then start → counts frozen at 00:03 during PAUSE. After resume, 00:02 appears 2 cycles later; subsequent ticks every 4 cycles.
- Load 60:00 + start (also 00:60) → load_err one-cycle pulse; state stays IDLE, counts 00:00, busy=0.
- Load 00:00 + start → next cycle done=1 for one cycle, expired=1, busy=0. A later start with 00:02 reruns, and expired clears.
- RUN at 00:05 with clear+pause+start asserted together → IDLE next cycle, counts 00:00, paused=0, busy=0.
- Reset asserted mid-RUN at 00:40 → next edge: all outputs 0; no done pulse afterward without a new start.
